// File: rtl/cordic_req_arbiter.sv
// Round-robin arbiter sharing one CORDIC core between NUM_REQ requesters.
// Optional WAIT-state watchdog enabled by defining CORDIC_TIMEOUT_EN.
module cordic_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [32*NUM_REQ-1:0] req_theta_deg,
    input  logic [NUM_REQ-1:0]    req_mode,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_result,
    output logic                  rsp_err,
    output logic                  core_start,
    output logic                  core_mode,
    output logic [31:0]           core_theta_deg,
    output logic                  core_rst,
    input  logic [31:0]           core_result_out,
    input  logic                  core_done,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state_reg;
    logic [ID_W-1:0]   ptr_reg;
    logic [ID_W-1:0]   gnt_id_reg;
    logic [31:0]       theta_reg;
    logic              mode_reg;
    logic              start_reg;
    logic              done_q_reg;
    logic              rsp_valid_reg;
    logic [ID_W-1:0]   rsp_id_reg;
    logic [31:0]       rsp_result_reg;
    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W:0]     scan_sum;
    logic              completion;
    logic [31:0]       theta_arr [NUM_REQ];

`ifdef CORDIC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]  wait_cnt_reg;
    logic              abort_reg;
    logic              rsp_err_reg;
`endif

    if (NUM_REQ < 2 || NUM_REQ > 8 || ID_W != $clog2(NUM_REQ) || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("cordic_req_arbiter: inconsistent NUM_REQ/ID_W/TIMEOUT_CYCLES");
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_theta
            assign theta_arr[gi] = req_theta_deg[32*gi +: 32];
        end
    endgenerate

    // Scan ptr, ptr+1, ... (mod NUM_REQ) and take the first valid requester.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_sum    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, ptr_reg} + (ID_W+1)'(k);
            if (scan_sum >= (ID_W+1)'(NUM_REQ))
                scan_sum = scan_sum - (ID_W+1)'(NUM_REQ);
            if (!grant_found && req_valid[scan_sum[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_sum[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_reg == IDLE && grant_found)
            req_ready[grant_idx] = 1'b1;
    end

    // done_q is forced high in ISSUE so a done level left over from the
    // previous operation is never mistaken for a rising edge.
    assign completion = core_done && !done_q_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            ptr_reg        <= '0;
            gnt_id_reg     <= '0;
            theta_reg      <= '0;
            mode_reg       <= 1'b0;
            start_reg      <= 1'b0;
            done_q_reg     <= 1'b0;
            rsp_valid_reg  <= 1'b0;
            rsp_id_reg     <= '0;
            rsp_result_reg <= '0;
`ifdef CORDIC_TIMEOUT_EN
            wait_cnt_reg   <= '0;
            abort_reg      <= 1'b0;
            rsp_err_reg    <= 1'b0;
`endif
        end else begin
            start_reg  <= 1'b0;
            done_q_reg <= core_done;
`ifdef CORDIC_TIMEOUT_EN
            abort_reg  <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (grant_found) begin
                        theta_reg  <= theta_arr[grant_idx];
                        mode_reg   <= req_mode[grant_idx];
                        gnt_id_reg <= grant_idx;
                        start_reg  <= 1'b1;
                        state_reg  <= ISSUE;
                    end
                end
                ISSUE: begin
                    done_q_reg <= 1'b1;
`ifdef CORDIC_TIMEOUT_EN
                    wait_cnt_reg <= '0;
`endif
                    state_reg  <= WAIT;
                end
                WAIT: begin
                    if (completion) begin
                        rsp_result_reg <= core_result_out;
                        rsp_id_reg     <= gnt_id_reg;
                        rsp_valid_reg  <= 1'b1;
`ifdef CORDIC_TIMEOUT_EN
                        rsp_err_reg    <= 1'b0;
`endif
                        state_reg      <= RESP;
`ifdef CORDIC_TIMEOUT_EN
                    end else if (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        abort_reg      <= 1'b1;
                        rsp_result_reg <= '0;
                        rsp_id_reg     <= gnt_id_reg;
                        rsp_err_reg    <= 1'b1;
                        rsp_valid_reg  <= 1'b1;
                        state_reg      <= RESP;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
`endif
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        if (gnt_id_reg == ID_W'(NUM_REQ - 1))
                            ptr_reg <= '0;
                        else
                            ptr_reg <= gnt_id_reg + 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign rsp_valid      = rsp_valid_reg;
    assign rsp_id         = rsp_id_reg;
    assign rsp_result     = rsp_result_reg;
    assign core_start     = start_reg;
    assign core_mode      = mode_reg;
    assign core_theta_deg = theta_reg;
    assign busy           = (state_reg != IDLE);
`ifdef CORDIC_TIMEOUT_EN
    assign rsp_err        = rsp_err_reg;
    assign core_rst       = rst | abort_reg;
`else
    assign rsp_err        = 1'b0;
    assign core_rst       = rst;
`endif

endmodule

// File: tb/tb_cordic_req_arbiter.sv
// Self-checking bench for cordic_req_arbiter: table of grant scenarios, a
// behavioural core model and a response scoreboard, plus corner-case sequences.
module tb_cordic_req_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic [32*NUM_REQ-1:0] req_theta_deg = '0;
    logic [NUM_REQ-1:0]    req_mode = '0;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b1;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_result;
    logic                  rsp_err;
    logic                  core_start;
    logic                  core_mode;
    logic [31:0]           core_theta_deg;
    logic                  core_rst;
    logic [31:0]           core_result_out;
    logic                  core_done = 1'b0;
    logic                  busy;

    always #5 clk = ~clk;

    cordic_req_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_theta_deg(req_theta_deg), .req_mode(req_mode),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_err(rsp_err),
        .core_start(core_start), .core_mode(core_mode),
        .core_theta_deg(core_theta_deg), .core_rst(core_rst),
        .core_result_out(core_result_out), .core_done(core_done),
        .busy(busy)
    );

    function automatic logic [31:0] model_res(logic [31:0] th, logic m);
        return th * 32'd7 + {31'd0, m};
    endfunction

    // Core model: done rises core_lat cycles after start and then stays high.
    int          core_lat = 18;
    logic        core_never = 1'b0;
    logic        core_stale = 1'b0;
    logic        c_run = 1'b0;
    int          c_cyc = 0;
    logic [31:0] c_res = '0;
    assign core_result_out = c_res;

    always @(posedge clk) begin
        if (core_rst) begin
            c_run     <= 1'b0;
            core_done <= 1'b0;
        end else if (core_start) begin
            c_run <= 1'b1;
            c_cyc <= 1;
            c_res <= model_res(core_theta_deg, core_mode);
            if (!core_stale) core_done <= 1'b0;
        end else if (c_run) begin
            c_cyc <= c_cyc + 1;
            if (core_stale && c_cyc + 1 == 2) core_done <= 1'b0;
            if (!core_never && c_cyc + 1 == core_lat) begin
                core_done <= 1'b1;
                c_run     <= 1'b0;
            end
        end
    end

    typedef struct {
        int          id;
        logic [31:0] theta;
        logic [31:0] result;
        logic        err;
        int          hs_cycle;
        int          lat;
    } exp_t;

    exp_t               exp_q[$];
    int                 n_cmp = 0;
    int                 n_bad = 0;
    int                 cycle = 0;
    int                 n_req_hs = 0;
    int                 n_rsp_hs = 0;
    int                 last_gnt = -1;
    int                 last_req_cycle = 0;
    int                 last_rsp_cycle = 0;
    int                 stall_left = 0;
    int                 abort_cnt = 0;
    logic [NUM_REQ-1:0] reload = '0;
    logic [NUM_REQ-1:0] hs_mask = '0;
    logic               prev_rsp_valid = 1'b0;
    logic               expect_timeout = 1'b0;
    logic [31:0]        theta_seed = 32'd500;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic sample();
        cycle++;
`ifndef CORDIC_TIMEOUT_EN
        check("core_rst_eq_rst", core_rst, rst);
`endif
        if (core_rst && !rst) abort_cnt++;
        if (rst) begin
            hs_mask = '0;
            exp_q.delete();
            prev_rsp_valid = 1'b0;
            return;
        end
        if (busy && req_ready != '0) check("req_ready_when_busy", req_ready, 0);
        if ($countones(req_ready) > 1) check("req_ready_onehot", $countones(req_ready), 1);
        hs_mask = req_valid & req_ready;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (hs_mask[i]) begin
                exp_t e;
                e.id       = i;
                e.theta    = req_theta_deg[32*i +: 32];
                e.err      = expect_timeout;
                e.result   = expect_timeout ? 32'd0 : model_res(e.theta, req_mode[i]);
                e.hs_cycle = cycle;
                e.lat      = expect_timeout ? -1 : core_lat;
                exp_q.push_back(e);
                n_req_hs++;
                last_gnt = i;
                last_req_cycle = cycle;
                $display("req  cycle=%0d id=%0d theta=%0d", cycle, i, e.theta);
            end
        end
        if (core_start) begin
            if (exp_q.size() == 0) begin
                check("core_start_without_request", 1, 0);
            end else begin
                check("core_start_cycle", cycle, exp_q[$].hs_cycle + 1);
                check("core_theta_deg", core_theta_deg, exp_q[$].theta);
            end
        end
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 1, 0);
            end else begin
                if (!prev_rsp_valid && exp_q[0].lat > 0)
                    check("rsp_latency", cycle - exp_q[0].hs_cycle, exp_q[0].lat + 2);
                check("rsp_id", rsp_id, exp_q[0].id);
                check("rsp_result", rsp_result, exp_q[0].result);
                check("rsp_err", rsp_err, exp_q[0].err);
                if (rsp_ready) begin
                    $display("rsp  cycle=%0d id=%0d result=%0d err=%0d", cycle, rsp_id, rsp_result, rsp_err);
                    void'(exp_q.pop_front());
                    n_rsp_hs++;
                    last_rsp_cycle = cycle;
                end
            end
            if (stall_left > 0) stall_left--;
        end
        prev_rsp_valid = rsp_valid && !rsp_ready;
    endtask

    task automatic apply();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (hs_mask[i]) begin
                if (reload[i]) begin
                    theta_seed = theta_seed + 32'd17;
                    req_theta_deg[32*i +: 32] = theta_seed;
                    req_mode[i] = ~req_mode[i];
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        hs_mask = '0;
        rsp_ready = (stall_left == 0);
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        apply();
    endtask

    task automatic wait_req(input int target, input int budget);
        int b = 0;
        while (n_req_hs < target && b < budget) begin step(); b++; end
        check("wait_req_bound", n_req_hs, target);
    endtask

    task automatic drain(input int budget);
        int b = 0;
        while (exp_q.size() != 0 && b < budget) begin step(); b++; end
        check("drain_bound", exp_q.size(), 0);
    endtask

    typedef struct {
        logic [NUM_REQ-1:0] mask;
        int                 lat;
        int                 exp_gnt;
    } vec_t;

    vec_t vecs[9];
    int   rr_exp[5];
    int   n0;
    int   g_cycle;

    initial begin
        // Grant sequence from ptr=0; ptr moves to winner+1 after each response.
        vecs[0] = '{4'b0100, 18, 2};
        vecs[1] = '{4'b1111,  4, 3};
        vecs[2] = '{4'b1111,  6, 0};
        vecs[3] = '{4'b0001,  3, 0};
        vecs[4] = '{4'b0001,  2, 0};
        vecs[5] = '{4'b1010,  5, 1};
        vecs[6] = '{4'b1010,  7, 3};
        vecs[7] = '{4'b1100,  3, 2};
        vecs[8] = '{4'b0110,  4, 1};
        rr_exp = '{0, 1, 2, 3, 0};

        repeat (3) begin
            @(negedge clk);
            check("reset_core_rst", core_rst, 1);
        end
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_id", rsp_id, 0);
        check("reset_rsp_result", rsp_result, 0);
        check("reset_rsp_err", rsp_err, 0);
        check("reset_core_start", core_start, 0);
        check("reset_core_mode", core_mode, 0);
        check("reset_core_theta", core_theta_deg, 0);
        check("reset_busy", busy, 0);
        check("reset_req_ready", req_ready, 0);
        @(posedge clk); #1;

        for (int k = 0; k < 9; k++) begin
            core_lat = vecs[k].lat;
            for (int i = 0; i < NUM_REQ; i++) begin
                req_theta_deg[32*i +: 32] = (k == 0) ? 32'd30 : 32'(1000 * k + i);
                req_mode[i] = (k == 0) ? 1'b0 : 1'(i + k);
            end
            req_valid = vecs[k].mask;
            n0 = n_req_hs + 1;
            wait_req(n0, 40);
            check("table_grant", last_gnt, vecs[k].exp_gnt);
            req_valid = '0;
            drain(100);
            check("table_grant_count", n_req_hs, n0);
        end

        // Stale done: done still high from the previous op, drops 2 cycles after start.
        core_stale = 1'b1;
        core_lat = 10;
        req_theta_deg[32*1 +: 32] = 32'd77;
        req_valid = 4'b0010;
        wait_req(n_req_hs + 1, 40);
        check("stale_grant", last_gnt, 1);
        req_valid = '0;
        drain(100);
        core_stale = 1'b0;

        // Response back-pressure for 10 cycles, then next grant one cycle later.
        core_lat = 6;
        stall_left = 10;
        rsp_ready = 1'b0;
        req_theta_deg[32*3 +: 32] = 32'd123;
        req_valid = 4'b1000;
        wait_req(n_req_hs + 1, 40);
        check("bp_grant", last_gnt, 3);
        g_cycle = last_req_cycle;
        req_valid = 4'b0001;
        req_theta_deg[32*0 +: 32] = 32'd321;
        n0 = n_rsp_hs + 1;
        while (n_rsp_hs < n0 && cycle < g_cycle + 60) step();
        check("bp_rsp_cycle", last_rsp_cycle, g_cycle + 2 + 6 + 10);
        wait_req(n_req_hs + 1, 10);
        check("bp_next_grant_id", last_gnt, 0);
        check("bp_next_grant_cycle", last_req_cycle, last_rsp_cycle + 1);
        req_valid = '0;
        drain(100);

        // Reset in the middle of WAIT: request dropped, pointer back to 0.
        core_lat = 40;
        req_theta_deg[32*1 +: 32] = 32'd999;
        req_valid = 4'b0010;
        wait_req(n_req_hs + 1, 40);
        check("midwait_grant", last_gnt, 1);
        req_valid = '0;
        repeat (6) step();
        rst = 1'b1;
        @(negedge clk);
        check("midwait_core_rst", core_rst, 1);
        sample();
        @(posedge clk); #1; apply();
        rst = 1'b0;
        @(negedge clk);
        check("midwait_rsp_valid", rsp_valid, 0);
        check("midwait_busy", busy, 0);
        check("midwait_core_theta", core_theta_deg, 0);
        check("midwait_rsp_result", rsp_result, 0);
        check("midwait_rsp_id", rsp_id, 0);
        sample();
        @(posedge clk); #1; apply();
        n0 = n_rsp_hs;
        repeat (60) step();
        check("midwait_no_rsp", n_rsp_hs, n0);

        // Round-robin with all requesters continuously valid.
        core_lat = 5;
        for (int i = 0; i < NUM_REQ; i++) req_theta_deg[32*i +: 32] = 32'(40 + i);
        reload = 4'hF;
        req_valid = 4'hF;
        for (int g = 0; g < 5; g++) begin
            wait_req(n_req_hs + 1, 40);
            check("rr_order", last_gnt, rr_exp[g]);
        end
        reload = '0;
        req_valid = '0;
        drain(100);

`ifdef CORDIC_TIMEOUT_EN
        // Core never finishes: watchdog aborts and returns an error response.
        core_never = 1'b1;
        expect_timeout = 1'b1;
        abort_cnt = 0;
        req_theta_deg[32*2 +: 32] = 32'd45;
        req_valid = 4'b0100;
        wait_req(n_req_hs + 1, 40);
        g_cycle = last_req_cycle;
        expect_timeout = 1'b0;
        req_valid = '0;
        drain(200);
        check("timeout_abort_pulses", abort_cnt, 1);
        check("timeout_rsp_cycle", last_rsp_cycle, g_cycle + 66);
        core_never = 1'b0;
        core_lat = 8;
        req_theta_deg[32*3 +: 32] = 32'd60;
        req_valid = 4'b1000;
        wait_req(n_req_hs + 1, 40);
        req_valid = '0;
        drain(100);
`endif

        check("final_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running required finished");
        $fatal(1, "bench time limit exceeded");
    end

endmodule
